// File: rtl/delay_pkg.sv
// Shared definitions for the delay sequencer: delay range, reset value,
// step FSM state encoding and the zero-delay substitution rule.
package delay_pkg;

    localparam int DELAY_W = 4;

    localparam logic [DELAY_W-1:0] DELAY_MIN   = 4'd1;
    localparam logic [DELAY_W-1:0] DELAY_MAX   = 4'd15;
    localparam logic [DELAY_W-1:0] DELAY_RESET = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // A zero delay would mean a zero-length period, so it runs as the minimum.
    function automatic logic [DELAY_W-1:0] effective_delay(input logic [DELAY_W-1:0] d);
        return (d < DELAY_MIN) ? DELAY_MIN : d;
    endfunction

endpackage

// File: rtl/delay_step_sched_key_debounce.sv
// One push-button channel: 2-flop synchroniser, stable-sample debouncer and a
// single-cycle pulse when the debounced level goes released->pressed.
module key_debounce #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_n;
    logic [DEB_W-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample pre-edge values;
    // with blocking '=' sync2 would see the new sync1 and the synchroniser collapses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_n <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level_n) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt     <= '0;
                level_n <= sync2;
                press   <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_step_sched.sv
// Delay sequencer: conditions the faster/slower keys into pulses and turns the
// current delay into a periodic one-cycle step strobe with a wrapping counter.
module delay_step_sched
    import delay_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int PRE_W      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_faster_n,
    input  logic               key_slower_n,
    input  logic               run,
    input  logic [DELAY_W-1:0] delay,
    output logic               faster,
    output logic               slower,
    output logic               step,
    output logic [7:0]         step_count
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic faster_press;
    logic slower_press;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_key_faster (
        .clk   (clk),
        .reset (reset),
        .key_n (key_faster_n),
        .press (faster_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_key_slower (
        .clk   (clk),
        .reset (reset),
        .key_n (key_slower_n),
        .press (slower_press)
    );

    // Faster wins a same-cycle collision; the slower request is dropped.
    assign faster = faster_press;
    assign slower = slower_press & ~faster_press;

    logic [0:0]         state;
    logic [PRE_W-1:0]   pre_cnt;
    logic [DELAY_W-1:0] unit_cnt;
    logic [DELAY_W-1:0] delay_q;
    logic               pre_wrap;
    logic               unit_last;

    assign pre_wrap  = (pre_cnt == PRE_LAST);
    assign unit_last = (unit_cnt == delay_q - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pre_cnt    <= '0;
            unit_cnt   <= '0;
            delay_q    <= DELAY_RESET;
            step       <= 1'b0;
            step_count <= '0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pre_cnt  <= '0;
                    unit_cnt <= '0;
                    if (run) begin
                        state   <= ST_RUN;
                        delay_q <= effective_delay(delay);
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        // Leaving RUN wins over a coincident terminal count.
                        state    <= ST_IDLE;
                        pre_cnt  <= '0;
                        unit_cnt <= '0;
                    end else if (pre_wrap) begin
                        pre_cnt <= '0;
                        if (unit_last) begin
                            unit_cnt   <= '0;
                            step       <= 1'b1;
                            step_count <= step_count + 1'b1;
                            delay_q    <= effective_delay(delay);
                        end else begin
                            unit_cnt <= unit_cnt + 1'b1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_step_sched.sv
// Self-checking bench for delay_step_sched: directed timing sequences, a period
// table and randomized traffic compared against an event-level reference model.
module tb_delay_step_sched;

    localparam int PRESCALE   = 4;
    localparam int PRE_W      = 3;
    localparam int DEB_CYCLES = 3;
    localparam int DEB_W      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_faster_n = 1'b1;
    logic       key_slower_n = 1'b1;
    logic       run = 1'b0;
    logic [3:0] delay = 4'd8;
    logic       faster;
    logic       slower;
    logic       step;
    logic [7:0] step_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    delay_step_sched #(
        .PRESCALE   (PRESCALE),
        .PRE_W      (PRE_W),
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_faster_n (key_faster_n),
        .key_slower_n (key_slower_n),
        .run          (run),
        .delay        (delay),
        .faster       (faster),
        .slower       (slower),
        .step         (step),
        .step_count   (step_count)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keys: a synced sample is the raw level from two edges earlier; the
    // debounced level flips once the last DEB_CYCLES synced samples all disagree.
    // Steps: scheduled as absolute edge numbers, start + delay*PRESCALE.
    bit                  m_lvl   [2];
    bit [1:0]            m_dl    [2];
    bit [DEB_CYCLES-1:0] m_win   [2];
    bit                  m_pulse [2];
    bit                  m_raw   [2];
    bit                  m_running;
    bit                  m_step;
    bit [7:0]            m_cnt;
    int                  m_edge = 0;
    int                  m_next;

    function automatic int eff(input logic [3:0] d);
        return (d == 4'd0) ? 1 : int'(d);
    endfunction

    always @(posedge clk) begin
        m_edge++;
        m_raw[0] = key_faster_n;
        m_raw[1] = key_slower_n;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_lvl[k]   = 1'b1;
                m_dl[k]    = 2'b11;
                m_win[k]   = '1;
                m_pulse[k] = 1'b0;
            end
            m_running = 1'b0;
            m_step    = 1'b0;
            m_cnt     = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_win[k]   = {m_win[k][DEB_CYCLES-2:0], m_dl[k][1]};
                m_pulse[k] = 1'b0;
                if (m_win[k] == {DEB_CYCLES{~m_lvl[k]}}) begin
                    m_lvl[k]   = ~m_lvl[k];
                    m_pulse[k] = (m_lvl[k] == 1'b0);
                end
                m_dl[k] = {m_dl[k][0], m_raw[k]};
            end
            m_step = 1'b0;
            if (!m_running) begin
                if (run) begin
                    m_running = 1'b1;
                    m_next    = m_edge + eff(delay) * PRESCALE;
                end
            end else if (!run) begin
                m_running = 1'b0;
            end else if (m_edge == m_next) begin
                m_step = 1'b1;
                m_cnt  = m_cnt + 8'd1;
                m_next = m_edge + eff(delay) * PRESCALE;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_faster", faster, m_pulse[0]);
            check("model_slower", slower, m_pulse[1] & ~m_pulse[0]);
            check("model_step", step, m_step);
            check("model_step_count", step_count, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    int tcnt;
    int pf;
    int ps;
    int pf_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_k();
        tick();
        tcnt++;
        if (faster) begin
            pf++;
            if (pf == 1) pf_at = tcnt;
        end
        if (slower) ps++;
    endtask

    task automatic clear_k();
        tcnt  = 0;
        pf    = 0;
        ps    = 0;
        pf_at = -1;
    endtask

    task automatic wait_step(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (step) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] delay;
        int         period;
    } vec_t;

    vec_t vecs[5];
    int   n;
    int   total;
    int   saved;
    int   seen;

    initial begin
        vecs[0] = '{4'd1, 4};
        vecs[1] = '{4'd2, 8};
        vecs[2] = '{4'd0, 4};
        vecs[3] = '{4'd15, 60};
        vecs[4] = '{4'd7, 28};

        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_faster", faster, 0);
        check("rst_slower", slower, 0);
        check("rst_step", step, 0);
        check("rst_step_count", step_count, 0);
        reset = 1'b0;

        // Period 8 at delay 2, first step 8 cycles after the run edge.
        delay = 4'd2;
        run   = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            wait_step(n);
            check("t1_period", n, 8);
            check("t1_step_count", step_count, i);
        end

        // Mid-period delay change only affects the following periods.
        repeat (3) tick();
        delay = 4'd5;
        wait_step(n);
        check("t2_current_period", n + 3, 8);
        wait_step(n);
        check("t2_next_period", n, 20);
        wait_step(n);
        check("t2_later_period", n, 20);

        // Reset in the middle of a period.
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("t2_rst_step", step, 0);
        check("t2_rst_count", step_count, 0);
        reset = 1'b0;
        run   = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run = 1'b0;
            repeat (2) tick();
            delay = vecs[i].delay;
            run   = 1'b1;
            tick();
            wait_step(n);
            check($sformatf("tbl_first_d%0d", vecs[i].delay), n, vecs[i].period);
            wait_step(n);
            check($sformatf("tbl_next_d%0d", vecs[i].delay), n, vecs[i].period);
        end

        // run=0 exactly at the terminal edge suppresses the step.
        run = 1'b0;
        repeat (2) tick();
        delay = 4'd1;
        run   = 1'b1;
        tick();
        wait_step(n);
        check("t6_period", n, 4);
        saved = step_count;
        repeat (3) tick();
        run = 1'b0;
        tick();
        check("t6_no_step", step, 0);
        seen = 0;
        repeat (8) begin
            tick();
            if (step) seen++;
        end
        check("t6_idle_steps", seen, 0);
        check("t6_count_hold", step_count, saved);

        // 256 steps wrap the counter back to zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        delay = 4'd1;
        run   = 1'b1;
        tick();
        total = 0;
        for (int i = 1; i <= 256; i++) begin
            wait_step(n);
            total += n;
            if (i == 255) check("wrap_255", step_count, 255);
        end
        check("wrap_total_cycles", total, 256 * 4);
        check("wrap_zero", step_count, 0);
        run = 1'b0;

        // Key held low for 10 cycles: one pulse 5 cycles after the edge.
        clear_k();
        key_faster_n = 1'b0;
        repeat (10) tick_k();
        key_faster_n = 1'b1;
        repeat (10) tick_k();
        check("t3_pulses", pf, 1);
        check("t3_latency", pf_at, 5);

        // Bouncing key: only the final stable low produces a pulse.
        clear_k();
        for (int j = 0; j < 4; j++) begin
            key_faster_n = j[0];
            repeat (2) tick_k();
        end
        key_faster_n = 1'b0;
        tcnt = 0;
        repeat (15) tick_k();
        check("t4_pulses", pf, 1);
        check("t4_latency", pf_at, 5);
        key_faster_n = 1'b1;
        repeat (8) tick_k();

        // Slower alone, then both together.
        clear_k();
        key_slower_n = 1'b0;
        repeat (10) tick_k();
        key_slower_n = 1'b1;
        repeat (10) tick_k();
        check("t5_slower_alone", ps, 1);
        clear_k();
        key_faster_n = 1'b0;
        key_slower_n = 1'b0;
        repeat (10) tick_k();
        key_faster_n = 1'b1;
        key_slower_n = 1'b1;
        repeat (10) tick_k();
        check("t5_faster_pulses", pf, 1);
        check("t5_faster_latency", pf_at, 5);
        check("t5_slower_dropped", ps, 0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) key_faster_n = ~key_faster_n;
            if ($urandom_range(0, 5) == 0) key_slower_n = ~key_slower_n;
            if ($urandom_range(0, 149) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) delay = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
